sd_block_reader: RTL and testbench

- SPI-mode CMD17 single-block read sequencer. It sits directly upstream of the SPI byte engine inside the SD controller.
- Frames the command, polls R1, hunts the 0xFE start token, then streams 512 data bytes to the host.
- Checks the trailing CRC16 and reports one status code per transaction.
- Frees the CPU from byte-by-byte polling of the status/DATA registers.

---
 rtl/sd_pkg.sv | 29 ++
 rtl/crc16_ccitt.sv | 25 ++
 rtl/sd_block_reader.sv | 178 +++++++++++++++++
 tb/tb_sd_block_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared types, constants and CRC helper for the SD block reader
package sd_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_TRAIL, S_FINISH
    } state_t;

    localparam logic [2:0] ERR_OK            = 3'd0;
    localparam logic [2:0] ERR_R1_TIMEOUT    = 3'd1;
    localparam logic [2:0] ERR_R1_NONZERO    = 3'd2;
    localparam logic [2:0] ERR_TOKEN_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_DATA_TOKEN    = 3'd4;
    localparam logic [2:0] ERR_CRC           = 3'd5;

    localparam logic [7:0]  CMD17       = 8'h51;
    localparam logic [7:0]  START_TOKEN = 8'hFE;
    localparam logic [7:0]  FILL        = 8'hFF;
    localparam logic [15:0] CRC16_POLY  = 16'h1021;

    // Advance a CRC16 (MSB-first) by one whole byte.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] din);
        logic [15:0] c;
        c = crc ^ {din, 8'h00};
        for (int i = 0; i < 8; i++)
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        return c;
    endfunction

endpackage

// File: rtl/crc16_ccitt.sv
// crc16_ccitt: byte-serial CRC16 (poly 0x1021, init 0) accumulator
module crc16_ccitt
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_din,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    // Clear wins over update so a new block always starts from zero.
    always_ff @(posedge clk) begin
        if (!reset_n || i_clear)
            r_crc <= '0;
        else if (i_en)
            r_crc <= crc16_byte(r_crc, i_din);
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sd_block_reader.sv
// sd_block_reader: SPI-mode CMD17 single-block read sequencer
module sd_block_reader
    import sd_pkg::*;
#(
    parameter int R1_POLL_MAX    = 8,
    parameter int TOKEN_POLL_MAX = 4096,
    parameter bit BLOCK_ADDR     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_rd_start,
    input  logic [31:0] i_lba,
    output logic        o_busy,
    output logic        o_done,
    output logic [2:0]  o_err_code,
    output logic [7:0]  o_r1_out,
    output logic [7:0]  o_blk_data,
    output logic        o_blk_valid,
    output logic [8:0]  o_blk_idx,
    output logic        o_cs_req,
    output logic        o_spi_start,
    output logic [7:0]  o_spi_tx,
    input  logic [7:0]  i_spi_rx,
    input  logic        i_spi_done
);

    localparam int CW = $clog2(TOKEN_POLL_MAX) > 9 ? $clog2(TOKEN_POLL_MAX) : 9;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_arg;
    logic [7:0]    r_crc_hi;
    logic [2:0]    r_err;
    logic          r_busy, r_done, r_blk_valid, r_cs, r_spi_start;
    logic [2:0]    r_err_code;
    logic [7:0]    r_r1, r_blk_data, r_spi_tx;
    logic [8:0]    r_blk_idx;
    logic [15:0]   w_crc;
    logic [31:0]   w_arg;
    logic          w_crc_clear, w_crc_en;

    assign w_arg       = BLOCK_ADDR ? i_lba : {i_lba[22:0], 9'b0};
    assign w_crc_clear = (r_state == S_TOKEN) && i_spi_done && (i_spi_rx == START_TOKEN);
    assign w_crc_en    = (r_state == S_DATA) && i_spi_done;

    crc16_ccitt u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_crc_clear),
        .i_en    (w_crc_en),
        .i_din   (i_spi_rx),
        .o_crc   (w_crc)
    );

    // Transaction sequencer; every output is registered and each spi_done
    // that needs a follow-up byte re-arms spi_start on the next cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_arg       <= '0;
            r_crc_hi    <= '0;
            r_err       <= ERR_OK;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_code  <= ERR_OK;
            r_r1        <= 8'hFF;
            r_blk_data  <= '0;
            r_blk_valid <= 1'b0;
            r_blk_idx   <= '0;
            r_cs        <= 1'b0;
            r_spi_start <= 1'b0;
            r_spi_tx    <= FILL;
        end else begin
            r_spi_start <= 1'b0;
            r_done      <= 1'b0;
            r_blk_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (i_rd_start) begin
                    r_state     <= S_CMD;
                    r_busy      <= 1'b1;
                    r_cs        <= 1'b1;
                    r_err       <= ERR_OK;
                    r_err_code  <= ERR_OK;
                    r_arg       <= w_arg;
                    r_cnt       <= '0;
                    r_spi_start <= 1'b1;
                    r_spi_tx    <= CMD17;
                end
                S_CMD: if (i_spi_done) begin
                    r_spi_start <= 1'b1;
                    if (r_cnt == CW'(5)) begin
                        r_state  <= S_R1;
                        r_cnt    <= '0;
                        r_spi_tx <= FILL;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                        r_spi_tx <= (r_cnt == CW'(4)) ? FILL : r_arg[31:24];
                        r_arg    <= {r_arg[23:0], 8'h00};
                    end
                end
                S_R1: if (i_spi_done) begin
                    r_spi_start <= 1'b1;
                    r_spi_tx    <= FILL;
                    if (!i_spi_rx[7]) begin
                        r_r1    <= i_spi_rx;
                        r_cnt   <= '0;
                        r_state <= (i_spi_rx == 8'h00) ? S_TOKEN : S_TRAIL;
                        r_err   <= (i_spi_rx == 8'h00) ? ERR_OK : ERR_R1_NONZERO;
                    end else if (r_cnt == CW'(R1_POLL_MAX - 1)) begin
                        r_err   <= ERR_R1_TIMEOUT;
                        r_state <= S_TRAIL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_TOKEN: if (i_spi_done) begin
                    r_spi_start <= 1'b1;
                    r_spi_tx    <= FILL;
                    if (i_spi_rx == START_TOKEN) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                    end else if (i_spi_rx[7:4] == 4'h0) begin
                        r_err   <= ERR_DATA_TOKEN;
                        r_state <= S_TRAIL;
                    end else if (r_cnt == CW'(TOKEN_POLL_MAX - 1)) begin
                        r_err   <= ERR_TOKEN_TIMEOUT;
                        r_state <= S_TRAIL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: if (i_spi_done) begin
                    r_spi_start <= 1'b1;
                    r_blk_valid <= 1'b1;
                    r_blk_data  <= i_spi_rx;
                    r_blk_idx   <= r_cnt[8:0];
                    if (r_cnt[8:0] == 9'd511) begin
                        r_state <= S_CRC;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CRC: if (i_spi_done) begin
                    r_spi_start <= 1'b1;
                    if (r_cnt == '0) begin
                        r_crc_hi <= i_spi_rx;
                        r_cnt    <= CW'(1);
                    end else begin
                        r_err   <= ({r_crc_hi, i_spi_rx} == w_crc) ? ERR_OK : ERR_CRC;
                        r_state <= S_TRAIL;
                    end
                end
                S_TRAIL: if (i_spi_done) begin
                    r_state    <= S_FINISH;
                    r_busy     <= 1'b0;
                    r_cs       <= 1'b0;
                    r_done     <= 1'b1;
                    r_err_code <= r_err;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err_code  = r_err_code;
    assign o_r1_out    = r_r1;
    assign o_blk_data  = r_blk_data;
    assign o_blk_valid = r_blk_valid;
    assign o_blk_idx   = r_blk_idx;
    assign o_cs_req    = r_cs;
    assign o_spi_start = r_spi_start;
    assign o_spi_tx    = r_spi_tx;

endmodule

// File: tb/tb_sd_block_reader.sv
// tb_sd_block_reader: directed bench with an SPI card responder for sd_block_reader
module tb_sd_block_reader;

    typedef struct {
        logic        ba;
        logic [31:0] lba;
        int          r1_pre;
        logic [7:0]  r1;
        int          tok_pre;
        logic [7:0]  tok_fill;
        logic [7:0]  tok;
        int          ndata;
        logic [7:0]  crc_flip;
        logic [2:0]  exp_err;
        int          exp_nvalid;
        logic [7:0]  exp_r1;
        int          exp_ntx;
        logic [47:0] exp_cmd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n, rd_start, sel;
    logic [31:0] lba;
    logic [7:0]  i_spi_rx;
    logic        i_spi_done;

    logic       busy1, done1, bv1, cs1, ss1, busy0, done0, bv0, cs0, ss0;
    logic [2:0] err1, err0;
    logic [7:0] r1o1, bd1, tx1, r1o0, bd0, tx0;
    logic [8:0] bi1, bi0;

    logic       w_busy, w_done, w_bv, w_cs, w_ss;
    logic [2:0] w_err;
    logic [7:0] w_r1, w_bd, w_tx;
    logic [8:0] w_bi;

    int tests = 0, fails = 0;
    int ndone_t = 0, nvalid_t = 0, bad_t = 0, cs_bad_t = 0, bidx = 0;
    int rx_ptr = 0, rx_end = 0, wr = 0;
    logic [7:0] rx_buf [16384];
    logic [7:0] tx_log [$];
    vec_t vecs [7];

    always #5 clk = ~clk;

    sd_block_reader #(.BLOCK_ADDR(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .i_rd_start(rd_start & ~sel), .i_lba(lba),
        .o_busy(busy1), .o_done(done1), .o_err_code(err1), .o_r1_out(r1o1),
        .o_blk_data(bd1), .o_blk_valid(bv1), .o_blk_idx(bi1), .o_cs_req(cs1),
        .o_spi_start(ss1), .o_spi_tx(tx1), .i_spi_rx(i_spi_rx), .i_spi_done(i_spi_done)
    );

    sd_block_reader #(.BLOCK_ADDR(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .i_rd_start(rd_start & sel), .i_lba(lba),
        .o_busy(busy0), .o_done(done0), .o_err_code(err0), .o_r1_out(r1o0),
        .o_blk_data(bd0), .o_blk_valid(bv0), .o_blk_idx(bi0), .o_cs_req(cs0),
        .o_spi_start(ss0), .o_spi_tx(tx0), .i_spi_rx(i_spi_rx), .i_spi_done(i_spi_done)
    );

    assign w_busy = sel ? busy0 : busy1;
    assign w_done = sel ? done0 : done1;
    assign w_bv   = sel ? bv0   : bv1;
    assign w_cs   = sel ? cs0   : cs1;
    assign w_ss   = sel ? ss0   : ss1;
    assign w_err  = sel ? err0  : err1;
    assign w_r1   = sel ? r1o0  : r1o1;
    assign w_bd   = sel ? bd0   : bd1;
    assign w_tx   = sel ? tx0   : tx1;
    assign w_bi   = sel ? bi0   : bi1;

    // Bitwise CRC16 reference (poly 0x1021, init 0), one data bit at a time.
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
        logic fb;
        for (int k = 7; k >= 0; k--) begin
            fb = c[15] ^ b[k];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // Card responder: answers each spi_start one cycle later from the scripted buffer.
    initial begin
        i_spi_done = 1'b0;
        i_spi_rx   = 8'hFF;
        forever begin
            @(posedge clk); #1;
            while (w_ss) begin
                tx_log.push_back(w_tx);
                @(posedge clk); #1;
                i_spi_rx   = (rx_ptr < rx_end) ? rx_buf[rx_ptr] : 8'hFF;
                rx_ptr++;
                i_spi_done = 1'b1;
                @(posedge clk); #1;
                i_spi_done = 1'b0;
            end
        end
    end

    // Output monitor: done pulses, data strobes against the ramp pattern, CS held during exchanges.
    always @(negedge clk) begin
        if (w_done) ndone_t++;
        if (w_ss && !w_cs) cs_bad_t++;
        if (!w_busy) bidx = 0;
        else if (w_bv) begin
            if (w_bd !== bidx[7:0] || w_bi !== bidx[8:0]) bad_t++;
            bidx++;
            nvalid_t++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        if (wr < 16384) rx_buf[wr] = b;
        wr++;
    endtask

    task automatic build(input vec_t v);
        logic [15:0] crc;
        wr = rx_ptr;
        repeat (6) put(8'hFF);
        repeat (v.r1_pre) put(8'hFF);
        put(v.r1);
        repeat (v.tok_pre) put(v.tok_fill);
        put(v.tok);
        crc = 16'h0000;
        for (int i = 0; i < v.ndata; i++) begin
            put(i[7:0]);
            crc = crc_model(crc, i[7:0]);
        end
        if (v.ndata > 0) begin
            put(crc[15:8]);
            put(crc[7:0] ^ v.crc_flip);
        end
        rx_end = wr;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (w_done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start(input logic [31:0] a);
        lba = a;
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
    endtask

    task automatic run_row(input vec_t v, input string nm);
        int base_tx, base_done, base_nv, base_bad, base_cs, nonff;
        logic [47:0] cmd;
        bit got;
        sel = ~v.ba;
        build(v);
        base_tx = tx_log.size(); base_done = ndone_t; base_nv = nvalid_t;
        base_bad = bad_t; base_cs = cs_bad_t;
        pulse_start(v.lba);
        chk({nm, ".accept_busy"}, w_busy, 1'b1);
        chk({nm, ".accept_cs"}, w_cs, 1'b1);
        chk({nm, ".first_start"}, w_ss, 1'b1);
        chk({nm, ".first_tx"}, w_tx, 8'h51);
        repeat (3) @(posedge clk); #1;
        pulse_start(32'hDEAD_BEEF);
        wait_done(got);
        chk({nm, ".done_seen"}, got, 1'b1);
        chk({nm, ".err"}, w_err, v.exp_err);
        chk({nm, ".fin_busy"}, w_busy, 1'b0);
        chk({nm, ".fin_cs"}, w_cs, 1'b0);
        repeat (3) @(posedge clk); #1;
        cmd = '0;
        nonff = 0;
        for (int k = base_tx; k < tx_log.size(); k++) begin
            if (k < base_tx + 6) cmd = {cmd[39:0], tx_log[k]};
            else if (tx_log[k] !== 8'hFF) nonff++;
        end
        chk({nm, ".cmd_bytes"}, cmd, v.exp_cmd);
        chk({nm, ".ntx"}, tx_log.size() - base_tx, v.exp_ntx);
        chk({nm, ".poll_fill"}, nonff, 0);
        chk({nm, ".nvalid"}, nvalid_t - base_nv, v.exp_nvalid);
        chk({nm, ".data_bad"}, bad_t - base_bad, 0);
        chk({nm, ".r1_out"}, w_r1, v.exp_r1);
        chk({nm, ".ndone"}, ndone_t - base_done, 1);
        chk({nm, ".cs_during_xfer"}, cs_bad_t - base_cs, 0);
    endtask

    initial begin
        bit got;
        int base_done;
        reset_n = 1'b0; rd_start = 1'b0; lba = '0; sel = 1'b0;
        //          ba  lba            r1p r1     tp tfill  tok    nd   flip   err   nv   r1o    ntx   cmd
        vecs[0] = '{1'b1, 32'h0000_1234, 2, 8'h00, 2, 8'hA5, 8'hFE, 512, 8'h00, 3'd0, 512, 8'h00, 527,  48'h51_0000_1234_FF};
        vecs[1] = '{1'b0, 32'h0000_0003, 0, 8'h00, 0, 8'hFF, 8'hFE, 512, 8'h00, 3'd0, 512, 8'h00, 523,  48'h51_0000_0600_FF};
        vecs[2] = '{1'b1, 32'h0000_0007, 0, 8'h05, 0, 8'hFF, 8'hFE, 0,   8'h00, 3'd2, 0,   8'h05, 8,    48'h51_0000_0007_FF};
        vecs[3] = '{1'b1, 32'h0000_0008, 0, 8'hFF, 0, 8'hFF, 8'hFF, 0,   8'h00, 3'd1, 0,   8'h05, 15,   48'h51_0000_0008_FF};
        vecs[4] = '{1'b1, 32'h0000_0009, 0, 8'h00, 1, 8'hFF, 8'h08, 0,   8'h00, 3'd4, 0,   8'h00, 10,   48'h51_0000_0009_FF};
        vecs[5] = '{1'b1, 32'h0000_000A, 0, 8'h00, 0, 8'hFF, 8'hFF, 0,   8'h00, 3'd3, 0,   8'h00, 4104, 48'h51_0000_000A_FF};
        vecs[6] = '{1'b1, 32'hA5C3_0B0B, 0, 8'h00, 0, 8'hFF, 8'hFE, 512, 8'h01, 3'd5, 512, 8'h00, 523,  48'h51_A5C3_0B0B_FF};

        repeat (3) @(posedge clk); #1;
        chk("rst.busy", w_busy, 1'b0);
        chk("rst.done", w_done, 1'b0);
        chk("rst.cs", w_cs, 1'b0);
        chk("rst.spi_start", w_ss, 1'b0);
        chk("rst.err", w_err, 3'd0);
        chk("rst.r1_out", w_r1, 8'hFF);
        chk("rst.spi_tx", w_tx, 8'hFF);
        chk("rst.blk_valid", w_bv, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_row(vecs[i], $sformatf("row%0d", i));

        // rd_start during FINISH is dropped; rd_start the cycle after done is taken.
        sel = 1'b0;
        build(vecs[2]);
        pulse_start(32'h0000_0042);
        wait_done(got);
        chk("fin.done_seen", got, 1'b1);
        chk("fin.err", w_err, 3'd2);
        rd_start = 1'b1;
        @(posedge clk); #1;
        chk("fin.rd_ignored", w_busy, 1'b0);
        @(posedge clk); #1;
        rd_start = 1'b0;
        chk("fin.next_accepted", w_busy, 1'b1);
        chk("fin.next_tx", w_tx, 8'h51);
        wait_done(got);
        chk("fin.next_done", got, 1'b1);
        chk("fin.next_err", w_err, 3'd1);
        repeat (4) @(posedge clk); #1;

        // Reset in the middle of the data phase aborts without a done.
        sel = 1'b0;
        build(vecs[0]);
        pulse_start(vecs[0].lba);
        got = 1'b0;
        for (int c = 0; c < 5000 && !got; c++) begin
            @(negedge clk);
            if (w_bv && w_bi == 9'd200) got = 1'b1;
        end
        chk("abort.byte200_seen", got, 1'b1);
        reset_n = 1'b0;
        base_done = ndone_t;
        @(posedge clk); #1;
        chk("abort.busy", w_busy, 1'b0);
        chk("abort.cs", w_cs, 1'b0);
        chk("abort.done", w_done, 1'b0);
        chk("abort.r1_out", w_r1, 8'hFF);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk); #1;
        chk("abort.no_done", ndone_t - base_done, 0);
        chk("abort.idle", w_busy, 1'b0);
        run_row(vecs[0], "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
